// File: rtl/apb_vgachargen_memif.sv
// ---------------------------------------------------------------------------
// apb_vgachargen_memif
// APB3 slave that exposes the VGA character generator memories (character
// map, colour map, glyph table) to the CPU. Each memory is reached through a
// synchronous-read port: address/data/wen are registered here, read data
// comes back one cycle after the address is presented.
//
// Address map (paddr_i[15:14]):
//   00 character map, entry paddr_i[13:2]
//   01 colour map,    entry paddr_i[13:2]
//   10 glyph table,   entry paddr_i[9:3], paddr_i[2] picks the 32-bit half
//   11 reserved (completes immediately, no memory access)
//
// Glyph entries are 64 bits wide but APB is 32, so glyph writes are done as
// read-modify-write of the addressed entry.
//
// Ports:
//   clk_i, arstn_i           clock, asynchronous active-low reset
//   psel_i .. pslverr_o      APB3 slave
//   ch_map_*                 character-map port  (data CH_T_ADDR_WIDTH+1 bits)
//   col_map_*                colour-map port     (data 8 bits)
//   ch_t_rw_*                glyph-table port    (data 64 bits)
//
// Build option: define APB_VGACHARGEN_MEMIF_PSLVERR_EN to report reserved
// region accesses on pslverr_o; otherwise pslverr_o is tied low.
// ---------------------------------------------------------------------------
module apb_vgachargen_memif #(
  parameter int unsigned CH_MAP_ADDR_WIDTH  = 12,
  parameter int unsigned COL_MAP_ADDR_WIDTH = 12,
  parameter int unsigned CH_T_ADDR_WIDTH    = 7,
  parameter int unsigned CH_T_DATA_WIDTH    = 64
) (
  input  logic                          clk_i,
  input  logic                          arstn_i,
  // APB3 slave
  input  logic                          psel_i,
  input  logic                          penable_i,
  input  logic                          pwrite_i,
  input  logic [31:0]                   paddr_i,
  input  logic [31:0]                   pwdata_i,
  output logic [31:0]                   prdata_o,
  output logic                          pready_o,
  output logic                          pslverr_o,
  // character map
  output logic [CH_MAP_ADDR_WIDTH-1:0]  ch_map_addr_o,
  output logic [CH_T_ADDR_WIDTH:0]      ch_map_data_o,
  output logic                          ch_map_wen_o,
  input  logic [CH_T_ADDR_WIDTH:0]      ch_map_data_i,
  // colour map
  output logic [COL_MAP_ADDR_WIDTH-1:0] col_map_addr_o,
  output logic [7:0]                    col_map_data_o,
  output logic                          col_map_wen_o,
  input  logic [7:0]                    col_map_data_i,
  // glyph table
  output logic [CH_T_ADDR_WIDTH-1:0]    ch_t_rw_addr_o,
  output logic [CH_T_DATA_WIDTH-1:0]    ch_t_rw_data_o,
  output logic                          ch_t_rw_wen_o,
  input  logic [CH_T_DATA_WIDTH-1:0]    ch_t_rw_data_i
);

  localparam int unsigned APB_DW    = 32;
  localparam int unsigned CH_MAP_DW = CH_T_ADDR_WIDTH + 1;
  localparam int unsigned COL_DW    = 8;
  localparam int unsigned HALF_W    = CH_T_DATA_WIDTH / 2;
  localparam int unsigned MAP_IDX_W = 12;
  localparam int unsigned GLY_IDX_W = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_READ_DONE,
    S_RMW_WRITE,
    S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    RGN_CH    = 2'b00,
    RGN_COL   = 2'b01,
    RGN_GLYPH = 2'b10,
    RGN_RSVD  = 2'b11
  } region_t;

  // Registers and their next-state values
  state_t                        r_state,        w_state_nxt;
  region_t                       r_region,       w_region_nxt;
  logic                          r_half,         w_half_nxt;
  logic                          r_write,        w_write_nxt;
  logic [APB_DW-1:0]             r_wdata,        w_wdata_nxt;
  logic                          r_rd_phase,     w_rd_phase_nxt;
  logic [CH_MAP_ADDR_WIDTH-1:0]  r_ch_map_addr,  w_ch_map_addr_nxt;
  logic [CH_MAP_DW-1:0]          r_ch_map_data,  w_ch_map_data_nxt;
  logic                          r_ch_map_wen,   w_ch_map_wen_nxt;
  logic [COL_MAP_ADDR_WIDTH-1:0] r_col_map_addr, w_col_map_addr_nxt;
  logic [COL_DW-1:0]             r_col_map_data, w_col_map_data_nxt;
  logic                          r_col_map_wen,  w_col_map_wen_nxt;
  logic [CH_T_ADDR_WIDTH-1:0]    r_ch_t_addr,    w_ch_t_addr_nxt;
  logic [CH_T_DATA_WIDTH-1:0]    r_ch_t_data,    w_ch_t_data_nxt;
  logic                          r_ch_t_wen,     w_ch_t_wen_nxt;
  logic                          r_pready,       w_pready_nxt;
`ifdef APB_VGACHARGEN_MEMIF_PSLVERR_EN
  logic                          r_pslverr,      w_pslverr_nxt;
`endif

  logic                          w_setup;
  logic [MAP_IDX_W-1:0]          w_map_idx;
  logic [GLY_IDX_W-1:0]          w_gly_idx;
  logic [CH_T_DATA_WIDTH-1:0]    w_rmw_data;
  logic [APB_DW-1:0]             w_rdata;
  logic                          w_unused;

  assign w_setup   = psel_i & ~penable_i;
  assign w_map_idx = paddr_i[13:2];
  assign w_gly_idx = paddr_i[9:3];
  assign w_unused  = ^{paddr_i[31:16], paddr_i[1:0]};

  // New 32-bit half replaces the addressed half of the entry read back in T2
  always_comb begin
    w_rmw_data = ch_t_rw_data_i;
    if (r_half) begin
      w_rmw_data[CH_T_DATA_WIDTH-1:HALF_W] = HALF_W'(r_wdata);
    end else begin
      w_rmw_data[HALF_W-1:0] = HALF_W'(r_wdata);
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt        = r_state;
    w_region_nxt       = r_region;
    w_half_nxt         = r_half;
    w_write_nxt        = r_write;
    w_wdata_nxt        = r_wdata;
    w_rd_phase_nxt     = 1'b0;
    w_ch_map_addr_nxt  = r_ch_map_addr;
    w_ch_map_data_nxt  = r_ch_map_data;
    w_ch_map_wen_nxt   = 1'b0;
    w_col_map_addr_nxt = r_col_map_addr;
    w_col_map_data_nxt = r_col_map_data;
    w_col_map_wen_nxt  = 1'b0;
    w_ch_t_addr_nxt    = r_ch_t_addr;
    w_ch_t_data_nxt    = r_ch_t_data;
    w_ch_t_wen_nxt     = 1'b0;
    w_pready_nxt       = 1'b0;
`ifdef APB_VGACHARGEN_MEMIF_PSLVERR_EN
    w_pslverr_nxt      = 1'b0;
`endif

    unique case (r_state)
      S_IDLE: begin
        if (w_setup) begin
          w_region_nxt = region_t'(paddr_i[15:14]);
          w_half_nxt   = paddr_i[2];
          w_write_nxt  = pwrite_i;
          w_wdata_nxt  = pwdata_i;
          case (region_t'(paddr_i[15:14]))
            RGN_CH: begin
              w_ch_map_addr_nxt = CH_MAP_ADDR_WIDTH'(w_map_idx);
              if (pwrite_i) begin
                w_ch_map_data_nxt = CH_MAP_DW'(pwdata_i);
                w_ch_map_wen_nxt  = 1'b1;
                w_pready_nxt      = 1'b1;
                w_state_nxt       = S_WRITE;
              end else begin
                w_state_nxt = S_READ;
              end
            end
            RGN_COL: begin
              w_col_map_addr_nxt = COL_MAP_ADDR_WIDTH'(w_map_idx);
              if (pwrite_i) begin
                w_col_map_data_nxt = COL_DW'(pwdata_i);
                w_col_map_wen_nxt  = 1'b1;
                w_pready_nxt       = 1'b1;
                w_state_nxt        = S_WRITE;
              end else begin
                w_state_nxt = S_READ;
              end
            end
            RGN_GLYPH: begin
              // Reads and writes both fetch the entry first
              w_ch_t_addr_nxt = CH_T_ADDR_WIDTH'(w_gly_idx);
              w_state_nxt     = S_READ;
            end
            default: begin
              w_pready_nxt  = 1'b1;
`ifdef APB_VGACHARGEN_MEMIF_PSLVERR_EN
              w_pslverr_nxt = 1'b1;
`endif
              w_state_nxt   = S_ERROR;
            end
          endcase
        end
      end

      S_READ: begin
        if (!psel_i) begin
          // Master abandoned the transfer: nothing is written
          w_state_nxt = S_IDLE;
        end else if ((r_region == RGN_GLYPH) && r_write) begin
          // Phase 0 waits for read data; phase 1 merges and writes back
          if (!r_rd_phase) begin
            w_rd_phase_nxt = 1'b1;
          end else begin
            w_ch_t_data_nxt = w_rmw_data;
            w_ch_t_wen_nxt  = 1'b1;
            w_pready_nxt    = 1'b1;
            w_state_nxt     = S_RMW_WRITE;
          end
        end else begin
          w_pready_nxt = 1'b1;
          w_state_nxt  = S_READ_DONE;
        end
      end

      // Completing states (and abort from any of them) return to IDLE
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state        <= S_IDLE;
      r_region       <= RGN_CH;
      r_half         <= 1'b0;
      r_write        <= 1'b0;
      r_wdata        <= '0;
      r_rd_phase     <= 1'b0;
      r_ch_map_addr  <= '0;
      r_ch_map_data  <= '0;
      r_ch_map_wen   <= 1'b0;
      r_col_map_addr <= '0;
      r_col_map_data <= '0;
      r_col_map_wen  <= 1'b0;
      r_ch_t_addr    <= '0;
      r_ch_t_data    <= '0;
      r_ch_t_wen     <= 1'b0;
      r_pready       <= 1'b0;
`ifdef APB_VGACHARGEN_MEMIF_PSLVERR_EN
      r_pslverr      <= 1'b0;
`endif
    end else begin
      r_state        <= w_state_nxt;
      r_region       <= w_region_nxt;
      r_half         <= w_half_nxt;
      r_write        <= w_write_nxt;
      r_wdata        <= w_wdata_nxt;
      r_rd_phase     <= w_rd_phase_nxt;
      r_ch_map_addr  <= w_ch_map_addr_nxt;
      r_ch_map_data  <= w_ch_map_data_nxt;
      r_ch_map_wen   <= w_ch_map_wen_nxt;
      r_col_map_addr <= w_col_map_addr_nxt;
      r_col_map_data <= w_col_map_data_nxt;
      r_col_map_wen  <= w_col_map_wen_nxt;
      r_ch_t_addr    <= w_ch_t_addr_nxt;
      r_ch_t_data    <= w_ch_t_data_nxt;
      r_ch_t_wen     <= w_ch_t_wen_nxt;
      r_pready       <= w_pready_nxt;
`ifdef APB_VGACHARGEN_MEMIF_PSLVERR_EN
      r_pslverr      <= w_pslverr_nxt;
`endif
    end
  end

  // Read data arrives from the memory in T2, so prdata_o is steered from the
  // memory port rather than registered; it is zero outside READ_DONE.
  always_comb begin
    w_rdata = '0;
    if (r_state == S_READ_DONE) begin
      case (r_region)
        RGN_CH:    w_rdata = APB_DW'(ch_map_data_i);
        RGN_COL:   w_rdata = APB_DW'(col_map_data_i);
        RGN_GLYPH: w_rdata = r_half ? APB_DW'(ch_t_rw_data_i[CH_T_DATA_WIDTH-1:HALF_W])
                                    : APB_DW'(ch_t_rw_data_i[HALF_W-1:0]);
        default:   w_rdata = '0;
      endcase
    end
  end

  assign prdata_o       = w_rdata;
  assign pready_o       = r_pready;
`ifdef APB_VGACHARGEN_MEMIF_PSLVERR_EN
  assign pslverr_o      = r_pslverr;
`else
  assign pslverr_o      = 1'b0;
`endif
  assign ch_map_addr_o  = r_ch_map_addr;
  assign ch_map_data_o  = r_ch_map_data;
  assign ch_map_wen_o   = r_ch_map_wen;
  assign col_map_addr_o = r_col_map_addr;
  assign col_map_data_o = r_col_map_data;
  assign col_map_wen_o  = r_col_map_wen;
  assign ch_t_rw_addr_o = r_ch_t_addr;
  assign ch_t_rw_data_o = r_ch_t_data;
  assign ch_t_rw_wen_o  = r_ch_t_wen;

endmodule

// File: tb/tb_apb_vgachargen_memif.sv
// ---------------------------------------------------------------------------
// tb_apb_vgachargen_memif
// Directed APB transfers against apb_vgachargen_memif with behavioural
// synchronous-read memories attached. A transfer-level model predicts, per
// transfer, the completion cycle, read data, error flag and the single memory
// write (which memory, which cycle, address, data); a monitor checks every
// cycle against that prediction. Literal checks pin the worked examples.
// ---------------------------------------------------------------------------
module tb_apb_vgachargen_memif;

`ifdef APB_VGACHARGEN_MEMIF_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk_i;
  logic        arstn_i;
  logic        psel_i, penable_i, pwrite_i;
  logic [31:0] paddr_i, pwdata_i, prdata_o;
  logic        pready_o, pslverr_o;
  logic [11:0] ch_map_addr_o;
  logic [7:0]  ch_map_data_o, ch_map_data_i;
  logic        ch_map_wen_o;
  logic [11:0] col_map_addr_o;
  logic [7:0]  col_map_data_o, col_map_data_i;
  logic        col_map_wen_o;
  logic [6:0]  ch_t_rw_addr_o;
  logic [63:0] ch_t_rw_data_o, ch_t_rw_data_i;
  logic        ch_t_rw_wen_o;

  apb_vgachargen_memif dut (
    .clk_i          (clk_i),
    .arstn_i        (arstn_i),
    .psel_i         (psel_i),
    .penable_i      (penable_i),
    .pwrite_i       (pwrite_i),
    .paddr_i        (paddr_i),
    .pwdata_i       (pwdata_i),
    .prdata_o       (prdata_o),
    .pready_o       (pready_o),
    .pslverr_o      (pslverr_o),
    .ch_map_addr_o  (ch_map_addr_o),
    .ch_map_data_o  (ch_map_data_o),
    .ch_map_wen_o   (ch_map_wen_o),
    .ch_map_data_i  (ch_map_data_i),
    .col_map_addr_o (col_map_addr_o),
    .col_map_data_o (col_map_data_o),
    .col_map_wen_o  (col_map_wen_o),
    .col_map_data_i (col_map_data_i),
    .ch_t_rw_addr_o (ch_t_rw_addr_o),
    .ch_t_rw_data_o (ch_t_rw_data_o),
    .ch_t_rw_wen_o  (ch_t_rw_wen_o),
    .ch_t_rw_data_i (ch_t_rw_data_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Initial memory contents (shared by the memories and the reference copy)
  function automatic logic [7:0] init_ch(int i);
    return 8'(i * 7 + 3);
  endfunction
  function automatic logic [7:0] init_col(int i);
    if (i == 2) return 8'h1F;
    return 8'(i ^ 'h5A);
  endfunction
  function automatic logic [63:0] init_gl(int i);
    if (i == 3) return 64'h1122_3344_5566_7788;
    return {32'(i) * 32'h0101_0101, 32'hC0DE_0000 | 32'(i)};
  endfunction

  // Memories: synchronous read, write on wen
  logic [7:0]  mem_ch  [4096];
  logic [7:0]  mem_col [4096];
  logic [63:0] mem_gl  [128];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_ch[i]  = init_ch(i);
      mem_col[i] = init_col(i);
    end
    for (int i = 0; i < 128; i++) mem_gl[i] = init_gl(i);
    ch_map_data_i  = '0;
    col_map_data_i = '0;
    ch_t_rw_data_i = '0;
    forever begin
      @(posedge clk_i);
      ch_map_data_i  <= mem_ch[ch_map_addr_o];
      col_map_data_i <= mem_col[col_map_addr_o];
      ch_t_rw_data_i <= mem_gl[ch_t_rw_addr_o];
      if (ch_map_wen_o)  mem_ch[ch_map_addr_o]   <= ch_map_data_o;
      if (col_map_wen_o) mem_col[col_map_addr_o] <= col_map_data_o;
      if (ch_t_rw_wen_o) mem_gl[ch_t_rw_addr_o]  <= ch_t_rw_data_o;
    end
  end

  // Reference memory contents as the model believes them to be
  logic [7:0]  ref_ch  [4096];
  logic [7:0]  ref_col [4096];
  logic [63:0] ref_gl  [128];

  // Per-transfer prediction (cycle numbers count from T0 = 0)
  int          xfer_id = 0;
  int          e_lat   = 0;   // completing cycle, 0 = no completion expected
  logic [31:0] e_rd    = '0;
  logic        e_err   = 1'b0;
  int          e_wsel  = 0;   // 0 none, 1 char map, 2 colour map, 3 glyph
  int          e_wcyc  = 0;
  logic [63:0] e_waddr = '0;
  logic [63:0] e_wdata = '0;

  // Per-cycle monitor
  initial begin
    int   cyc;
    int   last_id;
    logic done;
    cyc = 0;
    last_id = 0;
    forever begin
      @(negedge clk_i);
      if (xfer_id != last_id) begin
        last_id = xfer_id;
        cyc = 0;
      end
      done = (e_lat != 0) && (cyc == e_lat);
      chk("pready", 64'(pready_o), 64'(done));
      chk("prdata", 64'(prdata_o), done ? 64'(e_rd) : 64'h0);
      chk("pslverr", 64'(pslverr_o), 64'(done && ERR_EN && e_err));
      chk("ch_map_wen", 64'(ch_map_wen_o), 64'((e_wsel == 1) && (cyc == e_wcyc)));
      chk("col_map_wen", 64'(col_map_wen_o), 64'((e_wsel == 2) && (cyc == e_wcyc)));
      chk("ch_t_rw_wen", 64'(ch_t_rw_wen_o), 64'((e_wsel == 3) && (cyc == e_wcyc)));
      if (ch_map_wen_o && e_wsel == 1) begin
        chk("ch_map_addr", 64'(ch_map_addr_o), e_waddr);
        chk("ch_map_data", 64'(ch_map_data_o), e_wdata);
      end
      if (col_map_wen_o && e_wsel == 2) begin
        chk("col_map_addr", 64'(col_map_addr_o), e_waddr);
        chk("col_map_data", 64'(col_map_data_o), e_wdata);
      end
      if (ch_t_rw_wen_o && e_wsel == 3) begin
        chk("ch_t_rw_addr", 64'(ch_t_rw_addr_o), e_waddr);
        chk("ch_t_rw_data", ch_t_rw_data_o, e_wdata);
      end
      cyc++;
    end
  end

  // One complete APB transfer; the model predicts its effect first
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      output logic [31:0] rd, output logic err, output int lat);
    int          mi, gi;
    logic        hf;
    logic [63:0] g;
    mi = int'(a[13:2]);
    gi = int'(a[9:3]);
    hf = a[2];
    @(posedge clk_i); #1;
    e_rd = '0; e_err = 1'b0; e_wsel = 0; e_wcyc = 0; e_waddr = '0; e_wdata = '0;
    case (a[15:14])
      2'b00: if (w) begin
        e_lat = 1; e_wsel = 1; e_wcyc = 1; e_waddr = 64'(mi); e_wdata = 64'(d[7:0]);
        ref_ch[mi] = d[7:0];
      end else begin
        e_lat = 2; e_rd = 32'(ref_ch[mi]);
      end
      2'b01: if (w) begin
        e_lat = 1; e_wsel = 2; e_wcyc = 1; e_waddr = 64'(mi); e_wdata = 64'(d[7:0]);
        ref_col[mi] = d[7:0];
      end else begin
        e_lat = 2; e_rd = 32'(ref_col[mi]);
      end
      2'b10: begin
        g = ref_gl[gi];
        if (w) begin
          e_lat = 3; e_wsel = 3; e_wcyc = 3; e_waddr = 64'(gi);
          e_wdata = hf ? {d, g[31:0]} : {g[63:32], d};
          ref_gl[gi] = e_wdata;
        end else begin
          e_lat = 2; e_rd = hf ? g[63:32] : g[31:0];
        end
      end
      default: begin
        e_lat = 1; e_err = 1'b1;
      end
    endcase
    xfer_id++;
    psel_i = 1'b1; penable_i = 1'b0; paddr_i = a; pwrite_i = w; pwdata_i = d;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    lat = 0; rd = '0; err = 1'b0;
    while (lat < 8) begin
      @(negedge clk_i);
      lat++;
      if (pready_o) begin
        rd  = prdata_o;
        err = pslverr_o;
        break;
      end
    end
    chk("xfer_latency", 64'(lat), 64'(e_lat));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_i); #1;
      psel_i = 1'b0; penable_i = 1'b0;
      e_lat = 0; e_wsel = 0; e_rd = '0; e_err = 1'b0;
      xfer_id++;
    end
  endtask

  // Glyph write interrupted at the start of T2 by psel drop or reset
  task automatic glyph_abort(input logic [31:0] a, input logic [31:0] d, input bit use_rst);
    @(posedge clk_i); #1;
    e_lat = 0; e_wsel = 0; e_rd = '0; e_err = 1'b0;
    xfer_id++;
    psel_i = 1'b1; penable_i = 1'b0; paddr_i = a; pwrite_i = 1'b1; pwdata_i = d;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0;
    if (use_rst) begin
      arstn_i = 1'b0;
      #1;
      chk("rst_async_addr", 64'(ch_t_rw_addr_o), 64'h0);
      chk("rst_async_wen", 64'(ch_t_rw_wen_o), 64'h0);
      repeat (2) @(posedge clk_i);
      #1 arstn_i = 1'b1;
    end
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ref_ch[i]  = init_ch(i);
      ref_col[i] = init_col(i);
    end
    for (int i = 0; i < 128; i++) ref_gl[i] = init_gl(i);
    arstn_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = '0; pwdata_i = '0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_pready", 64'(pready_o), 64'h0);
    chk("rst_prdata", 64'(prdata_o), 64'h0);
    chk("rst_pslverr", 64'(pslverr_o), 64'h0);
    chk("rst_wens", 64'({ch_map_wen_o, col_map_wen_o, ch_t_rw_wen_o}), 64'h0);
    chk("rst_ch_t_addr", 64'(ch_t_rw_addr_o), 64'h0);
    chk("rst_ch_map_data", 64'(ch_map_data_o), 64'h0);
    @(posedge clk_i); #1 arstn_i = 1'b1;
    idle(2);

    // Character-map write, zero wait states
    xfer(32'h0000_0010, 1'b1, 32'h0000_0041, rd, err, lat);
    chk("ex_ch_wr_lat", 64'(lat), 64'd1);
    idle(1);
    chk("ex_ch_wr_mem", 64'(mem_ch[4]), 64'h41);

    // Colour-map read, back-to-back into a glyph RMW write
    xfer(32'h0000_4008, 1'b0, 32'h0, rd, err, lat);
    chk("ex_col_rd_lat", 64'(lat), 64'd2);
    chk("ex_col_rd_data", 64'(rd), 64'h1F);
    xfer(32'h0000_801C, 1'b1, 32'hAABB_CCDD, rd, err, lat);
    chk("ex_gl_wr_lat", 64'(lat), 64'd3);
    idle(1);
    chk("ex_gl_wr_mem", mem_gl[3], 64'hAABB_CCDD_5566_7788);

    // Glyph read-back of both halves, back-to-back
    xfer(32'h0000_801C, 1'b0, 32'h0, rd, err, lat);
    chk("ex_gl_rd_hi", 64'(rd), 64'hAABB_CCDD);
    xfer(32'h0000_8018, 1'b0, 32'h0, rd, err, lat);
    chk("ex_gl_rd_lo", 64'(rd), 64'h5566_7788);

    // Lower-half glyph write, colour write, then verify through reads
    xfer(32'h0000_8010, 1'b1, 32'h1234_5678, rd, err, lat);
    xfer(32'h0000_43FC, 1'b1, 32'hFFFF_FF96, rd, err, lat);
    xfer(32'h0000_8010, 1'b0, 32'h0, rd, err, lat);
    xfer(32'h0000_43FC, 1'b0, 32'h0, rd, err, lat);
    chk("ex_col_rd_back", 64'(rd), 64'h96);

    // Reserved region: write and read both complete in T1, no memory write
    xfer(32'h0000_C000, 1'b1, 32'h0000_0055, rd, err, lat);
    chk("ex_rsvd_lat", 64'(lat), 64'd1);
    chk("ex_rsvd_err", 64'(err), 64'(ERR_EN));
    xfer(32'h0000_C004, 1'b0, 32'h0, rd, err, lat);
    chk("ex_rsvd_rd", 64'(rd), 64'h0);

    // paddr[1:0] and upper address bits are ignored; pwdata truncated
    xfer(32'h0000_0013, 1'b1, 32'h1234_56AB, rd, err, lat);
    xfer(32'h0000_0010, 1'b0, 32'h0, rd, err, lat);
    chk("ex_ch_rd_trunc", 64'(rd), 64'hAB);
    xfer(32'hFFFF_4008, 1'b0, 32'h0, rd, err, lat);
    chk("ex_col_rd_hiaddr", 64'(rd), 64'h1F);
    idle(1);

    // psel dropped in T2 of a glyph write: nothing written, next transfer fine
    glyph_abort(32'h0000_8008, 32'hDEAD_BEEF, 1'b0);
    idle(3);
    chk("abort_mem", mem_gl[1], ref_gl[1]);
    xfer(32'h0000_8008, 1'b0, 32'h0, rd, err, lat);
    idle(1);

    // Reset in T2 of a glyph write: nothing written, next transfer fine
    glyph_abort(32'h0000_8014, 32'hCAFE_F00D, 1'b1);
    idle(2);
    chk("rst_mid_mem", mem_gl[2], ref_gl[2]);
    xfer(32'h0000_8014, 1'b0, 32'h0, rd, err, lat);
    xfer(32'h0000_8014, 1'b1, 32'h0BAD_F00D, rd, err, lat);
    xfer(32'h0000_8014, 1'b0, 32'h0, rd, err, lat);
    chk("rst_mid_rd", 64'(rd), 64'h0BAD_F00D);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
